// File: rtl/float_div_iter.sv
// Sequential radix-2 floating-point divider q = a / b with valid/ready handshake and sideband tag.
// Subnormal inputs flush to zero; results round to nearest-even, with no subnormal outputs.
module float_div_iter #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_q,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               out_flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(MAN_W + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [EW-1:0] E_BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(MAN_W + 1);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MAN_W+1:0]       rem_q, rem_d;
  logic [MAN_W:0]         mb_q, mb_d;
  logic [MAN_W+2:0]       quo_q, quo_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [W-1:0]           res_q, res_d;
  logic [3:0]             flags_q, flags_d;

  logic                   sa, sb;
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic [MAN_W+1:0]       step_rem, step_next;
  logic [MAN_W:0]         step_mb, step_diff;
  logic                   step_bit;

  logic                   r_msb, r_guard, r_sticky, r_up;
  logic [MAN_W:0]         r_mant;
  logic [MAN_W+1:0]       r_sum;
  logic [MAN_W-1:0]       r_frac;
  logic signed [EW-1:0]   r_exp, r_exp_fin;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);

  // One restoring shift-subtract step; the first step runs in the accept cycle
  always_comb begin
    step_rem  = (state_q == S_IDLE) ? {2'b01, fa} : rem_q;
    step_mb   = (state_q == S_IDLE) ? {1'b1, fb} : mb_q;
    step_bit  = (step_rem >= {1'b0, step_mb});
    step_diff = step_bit ? (step_rem[MAN_W:0] - step_mb) : step_rem[MAN_W:0];
    step_next = {step_diff, 1'b0};
  end

  always_comb begin
    r_msb     = quo_q[MAN_W+2];
    r_mant    = r_msb ? quo_q[MAN_W+2:2] : quo_q[MAN_W+1:1];
    r_guard   = r_msb ? quo_q[1] : quo_q[0];
    r_sticky  = (r_msb & quo_q[0]) | (|rem_q);
    r_exp     = r_msb ? exp_q : (exp_q - E_ONE);
    r_up      = r_guard & (r_sticky | r_mant[0]);
    r_sum     = {1'b0, r_mant} + {{(MAN_W+1){1'b0}}, r_up};
    // On mantissa carry-out the sum is exactly 10..0, so its upper bits give a zero fraction
    r_frac    = r_sum[MAN_W+1] ? r_sum[MAN_W:1] : r_sum[MAN_W-1:0];
    r_exp_fin = r_sum[MAN_W+1] ? (r_exp + E_ONE) : r_exp;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mb_d    = mb_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    tag_d   = tag_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tag_d   = in_tag;
          sign_d  = sa ^ sb;
          flags_d = 4'b0000;
          state_d = S_DONE;
          if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            res_d   = QNAN;
            flags_d = 4'b1000;
          end else if (a_inf) begin
            res_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else if (b_zero) begin
            res_d   = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 4'b0100;
          end else if (b_inf | a_zero) begin
            res_d = {sa ^ sb, {(W-1){1'b0}}};
          end else begin
            state_d = S_DIV;
            cnt_d   = '0;
            rem_d   = step_next;
            mb_d    = {1'b1, fb};
            quo_d   = {{(MAN_W+2){1'b0}}, step_bit};
            exp_d   = {2'b00, ea} - {2'b00, eb} + E_BIAS;
          end
        end
      end
      S_DIV: begin
        rem_d = step_next;
        quo_d = {quo_q[MAN_W+1:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = S_ROUND;
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (r_exp_fin >= E_MAX) begin
          res_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0010;
        end else if (r_exp_fin <= E_ZERO) begin
          res_d   = {sign_q, {(W-1){1'b0}}};
          flags_d = 4'b0001;
        end else begin
          res_d   = {sign_q, r_exp_fin[EXP_W-1:0], r_frac};
          flags_d = 4'b0000;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      mb_q    <= '0;
      quo_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      mb_q    <= mb_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_q     = res_q;
  assign out_tag   = tag_q;
  assign out_flags = out_valid ? flags_q : 4'b0000;

endmodule

// File: tb/tb_float_div_iter.sv
// Directed table-driven bench for float_div_iter at FP16 defaults, plus
// backpressure, back-to-back tag ordering and mid-operation reset sequences.
module tb_float_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_q;
  logic [3:0]  in_tag, out_tag, out_flags;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  float_div_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one op, waits (bounded) for the result and returns it with the observed latency
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                               output logic [15:0] q, output logic [3:0] flags,
                               output logic [3:0] tg, output int lat);
    int waits;
    in_a = a;
    in_b = b;
    in_tag = tag;
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    q = out_q;
    flags = out_flags;
    tg = out_tag;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] q;
    logic [3:0]  fl, tg, rtag;
    int          lat;
    logic        seen;

    vecs[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 14};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 4'b0000, 14};
    vecs[2]  = '{16'h4600, 16'h4000, 16'h4200, 4'b0000, 14};
    vecs[3]  = '{16'hBC00, 16'h4000, 16'hB800, 4'b0000, 14};
    vecs[4]  = '{16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 1};
    vecs[5]  = '{16'hBC00, 16'h0000, 16'hFC00, 4'b0100, 1};
    vecs[6]  = '{16'h0000, 16'h0000, 16'h7E00, 4'b1000, 1};
    vecs[7]  = '{16'h7C00, 16'h7C00, 16'h7E00, 4'b1000, 1};
    vecs[8]  = '{16'h7E01, 16'h3C00, 16'h7E00, 4'b1000, 1};
    vecs[9]  = '{16'h3C00, 16'h7C00, 16'h0000, 4'b0000, 1};
    vecs[10] = '{16'h7BFF, 16'h0400, 16'h7C00, 4'b0010, 14};
    vecs[11] = '{16'h0400, 16'h7BFF, 16'h0000, 4'b0001, 14};
    vecs[12] = '{16'h0001, 16'h3C00, 16'h0000, 4'b0000, 1};
    vecs[13] = '{16'h4200, 16'h4500, 16'h38CD, 4'b0000, 14};
    vecs[14] = '{16'h3C00, 16'h4500, 16'h3266, 4'b0000, 14};
    vecs[15] = '{16'h3C00, 16'h3C01, 16'h3BFE, 4'b0000, 14};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_q", 32'(out_q), 32'd0);
    checkOutput("reset out_tag", 32'(out_tag), 32'd0);
    checkOutput("reset out_flags", 32'(out_flags), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 4'(i), q, fl, tg, lat);
      checkOutput($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].q));
      checkOutput($sformatf("vec%0d flags", i), 32'(fl), 32'(vecs[i].flags));
      checkOutput($sformatf("vec%0d tag", i), 32'(tg), 32'(i));
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    out_ready = 1'b0;
    applyStimulus(16'h3C00, 16'h4200, 4'hA, q, fl, tg, lat);
    checkOutput("bp q", 32'(q), 32'h3555);
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("bp hold q c%0d", c), 32'(out_q), 32'h3555);
      checkOutput($sformatf("bp hold tag c%0d", c), 32'(out_tag), 32'hA);
      checkOutput($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp out_valid c%0d", c), 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp release flags", 32'(out_flags), 32'd0);

    for (int i = 0; i < 4; i++) begin
      rtag = 4'($urandom_range(0, 15));
      applyStimulus(vecs[i].a, vecs[i].b, rtag, q, fl, tg, lat);
      checkOutput($sformatf("b2b%0d tag", i), 32'(tg), 32'(rtag));
      checkOutput($sformatf("b2b%0d q", i), 32'(q), 32'(vecs[i].q));
    end

    in_a = 16'h3C00;
    in_b = 16'h4200;
    in_tag = 4'h7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid-op busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid-op rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid-op rst out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("mid-op no result", 32'(seen), 32'd0);
    applyStimulus(16'h4600, 16'h4000, 4'h5, q, fl, tg, lat);
    checkOutput("post-rst q", 32'(q), 32'h4200);
    checkOutput("post-rst tag", 32'(tg), 32'h5);
    checkOutput("post-rst latency", 32'(lat), 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
